weight_load_ctrl: RTL and testbench

- Sequences programming of the synapse weight register file, one weight per write, addresses 0..NUM_SYNAPSES-1.
- Weights come from one of two sources:
  - Random mode: the shared 8-bit LFSR, advanced only on a write.
  - External mode: a valid/ready byte stream from the chip I/O.
- Reports busy, completion and weight validity to the neuron core, which must not integrate while busy_o=1.

---
 rtl/weight_load_ctrl.sv | 133 +++++++++++++
 tb/tb_weight_load_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl
//   Sequences programming of the synapse weight register file, one weight per
//   write, addresses 0..NUM_SYNAPSES-1. Weights come either from the shared LFSR
//   (mode 0, LFSR advanced only on a write) or from an external valid/ready
//   byte stream (mode 1).
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, mode_i      begin a load (IDLE only) / source select latched at start
//   abort_i              cancel an in-progress load
//   rnd_i, rnd_en_o      LFSR value / advance LFSR this cycle
//   ext_valid_i,
//   ext_data_i,
//   ext_ready_o          external weight stream handshake
//   we_o, waddr_o,
//   wdata_o              weight file write port (combinational)
//   busy_o, done_o,
//   weights_valid_o,
//   count_o              registered status to the neuron core

module weight_load_ctrl #(
   parameter int unsigned NUM_SYNAPSES = 100,
   parameter int unsigned WIDTH_P      = 8,
   parameter int unsigned ADDR_W       = 7
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic               abort_i,
   input  logic [7:0]         rnd_i,
   output logic               rnd_en_o,
   input  logic               ext_valid_i,
   input  logic [WIDTH_P-1:0] ext_data_i,
   output logic               ext_ready_o,
   output logic               we_o,
   output logic [ADDR_W-1:0]  waddr_o,
   output logic [WIDTH_P-1:0] wdata_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               weights_valid_o,
   output logic [ADDR_W-1:0]  count_o
);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_SYNAPSES - 1);
   localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

   state_e              state_q;
   logic                mode_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   count_q;
   logic                busy_q;
   logic                done_q;
   logic                valid_q;

   logic                load_act;
   logic                wr_en;
   logic                last_wr;

   // Abort takes priority over any write in the same cycle.
   assign load_act = (state_q == StLoad) && !abort_i;
   assign wr_en    = load_act && (!mode_q || ext_valid_i);
   assign last_wr  = (addr_q == LastAddr);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         mode_q  <= 1'b0;
         addr_q  <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               // start wins over a simultaneous abort; abort alone is a no-op here
               if (start_i) begin
                  state_q <= StLoad;
                  mode_q  <= mode_i;
                  addr_q  <= '0;
                  count_q <= '0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            StLoad: begin
               if (abort_i) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (wr_en) begin
                  count_q <= count_q + AddrOne;
                  if (last_wr) begin
                     // addr stays on the last index; it never wraps
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q <= addr_q + AddrOne;
                  end
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               valid_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign we_o        = wr_en;
   assign rnd_en_o    = wr_en && !mode_q;
   assign ext_ready_o = load_act && mode_q;
   assign waddr_o     = addr_q;
   // Held at zero outside LOAD so the write bus is quiet in and after reset.
   assign wdata_o     = (state_q != StLoad) ? '0 :
                        (mode_q ? ext_data_i : rnd_i[WIDTH_P-1:0]);

   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign weights_valid_o = valid_q;
   assign count_o         = count_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
module tb_weight_load_ctrl;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 4;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, mode, abort, ext_valid;
   logic [W-1:0]  ext_data;
   logic [7:0]    lfsr;
   logic          rnd_en, ext_ready, we, busy, done, wvalid;
   logic [AW-1:0] waddr, count;
   logic [W-1:0]  wdata;

   // Default-parameter instance for the N=100 latency check
   logic          b_start;
   logic          b_rnd_en, b_ext_ready, b_we, b_busy, b_done, b_wvalid;
   logic [6:0]    b_waddr, b_count;
   logic [7:0]    b_wdata;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int rnd_cnt = 0;
   int b_wr_cnt = 0;
   logic cur_mode = 1'b0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   weight_load_ctrl #(.NUM_SYNAPSES(N), .WIDTH_P(W), .ADDR_W(AW)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .abort_i(abort),
      .rnd_i(lfsr), .rnd_en_o(rnd_en), .ext_valid_i(ext_valid), .ext_data_i(ext_data),
      .ext_ready_o(ext_ready), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
      .busy_o(busy), .done_o(done), .weights_valid_o(wvalid), .count_o(count)
   );

   weight_load_ctrl u_big (
      .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .mode_i(1'b0), .abort_i(1'b0),
      .rnd_i(8'hA5), .rnd_en_o(b_rnd_en), .ext_valid_i(1'b0), .ext_data_i(8'h00),
      .ext_ready_o(b_ext_ready), .we_o(b_we), .waddr_o(b_waddr), .wdata_o(b_wdata),
      .busy_o(b_busy), .done_o(b_done), .weights_valid_o(b_wvalid), .count_o(b_count)
   );

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Bench-side LFSR, advanced only when the controller asks for it
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 8'h2A;
      else if (rnd_en) lfsr <= lfsr_step(lfsr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         check("rnd_en_vs_we", {31'd0, rnd_en}, {31'd0, we && !cur_mode});
         if (we) begin
            check("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("waddr", {29'd0, waddr}, {29'd0, e.addr});
               check("wdata", {28'd0, wdata}, {28'd0, e.data});
            end
            wr_cnt++;
         end
         if (rnd_en) rnd_cnt++;
         if (b_we) b_wr_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_random(input int n);
      logic [7:0] v;
      v = lfsr;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({AW'(k), v[W-1:0]});
         v = lfsr_step(v);
      end
   endtask

   // Clock start/abort in, then count cycles until done_o (bounded)
   task automatic run_until_done(input string tag, input int exp_cycles);
      int n;
      tick();
      start = 1'b0;
      abort = 1'b0;
      n = 1;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      check(tag, n, exp_cycles);
   endtask

   initial begin
      int n;
      int w0, r0;
      int done_seen;
      logic [W-1:0] ext_words [4];
      ext_words[0] = 4'h1; ext_words[1] = 4'h2; ext_words[2] = 4'h3; ext_words[3] = 4'h4;

      rst_n = 1'b0; start = 0; mode = 0; abort = 0; ext_valid = 0; ext_data = '0;
      b_start = 0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_outs", {25'd0, we, rnd_en, ext_ready, done, wvalid, count != 0, waddr != 0},
            32'd0);
      rst_n = 1'b1;
      tick();

      // Random load, seed 0x2A
      cur_mode = 1'b0;
      push_random(N);
      w0 = wr_cnt; r0 = rnd_cnt;
      mode = 0; start = 1;
      run_until_done("rand_done_cycle", 5);
      check("rand_done_wvalid", {31'd0, wvalid}, 32'd0);
      check("rand_done_count", {29'd0, count}, N);
      check("rand_writes", wr_cnt - w0, N);
      check("rand_rnd_en", rnd_cnt - r0, N);
      tick();
      check("rand_wvalid", {31'd0, wvalid}, 32'd1);
      check("rand_q_empty", exp_q.size(), 0);

      // External load with 2-cycle valid gaps (low nibbles of 0x11..0x44)
      cur_mode = 1'b1;
      w0 = wr_cnt; r0 = rnd_cnt;
      mode = 1; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 4; i++) begin
         ext_valid = 0;
         repeat (2) begin
            #1;
            check("ext_gap_no_we", {31'd0, we}, 32'd0);
            tick();
         end
         exp_q.push_back({AW'(i), ext_words[i]});
         ext_valid = 1; ext_data = ext_words[i];
         #1;
         check("ext_ready", {31'd0, ext_ready}, 32'd1);
         tick();
      end
      ext_valid = 0;
      check("ext_done", {31'd0, done}, 32'd1);
      check("ext_writes", wr_cnt - w0, 4);
      check("ext_no_rnd_en", rnd_cnt - r0, 0);
      tick();
      cur_mode = 1'b0;

      // Abort after 2 writes in mode 0
      push_random(2);
      mode = 0; start = 1;
      tick();
      start = 0;
      check("abort_wvalid_cleared", {31'd0, wvalid}, 32'd0);
      tick();
      tick();
      abort = 1;
      #1;
      check("abort_no_write", {29'd0, we, rnd_en, ext_ready}, 32'd0);
      tick();
      abort = 0;
      check("abort_idle", {31'd0, busy}, 32'd0);
      check("abort_count", {29'd0, count}, 2);
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) done_seen++;
         tick();
      end
      check("abort_no_done", done_seen, 0);
      check("abort_wvalid", {31'd0, wvalid}, 32'd0);
      check("abort_q_empty", exp_q.size(), 0);

      // Restart after completion, with a start pulse during LOAD
      push_random(N);
      start = 1;
      run_until_done("restart_first_done", 5);
      tick();
      check("restart_wvalid_set", {31'd0, wvalid}, 32'd1);
      push_random(N);
      start = 1;
      tick();
      start = 0;
      n = 1;
      check("restart_wvalid_drop", {31'd0, wvalid}, 32'd0);
      tick(); n++;
      start = 1;
      tick(); n++;
      start = 0;
      while (!done && n < 50) begin
         tick();
         n++;
      end
      check("restart_ignored_start", n, 5);
      tick();
      check("restart_q_empty", exp_q.size(), 0);

      // Asynchronous reset during a mode-1 load at addr 2
      cur_mode = 1'b1;
      mode = 1; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({AW'(i), ext_words[i]});
         ext_valid = 1; ext_data = ext_words[i];
         tick();
      end
      ext_data = ext_words[2];
      check("rst_mid_addr", {29'd0, waddr}, 2);
      check("rst_mid_we", {31'd0, we}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      check("async_rst_outs",
            {21'd0, busy, done, wvalid, we, rnd_en, ext_ready, count != 0, waddr != 0,
             wdata != 0, 2'b00}, 32'd0);
      ext_valid = 0;
      #2;
      rst_n = 1;
      tick();
      exp_q.push_back({AW'(0), 4'hA});
      mode = 1; start = 1;
      tick();
      start = 0;
      ext_valid = 1; ext_data = 4'hA;
      tick();
      ext_valid = 0;
      check("post_rst_count", {29'd0, count}, 1);
      abort = 1;
      tick();
      abort = 0;
      check("post_rst_q_empty", exp_q.size(), 0);
      cur_mode = 1'b0;

      // Start and abort together in IDLE: load still starts
      push_random(N);
      mode = 0; start = 1; abort = 1;
      run_until_done("start_abort_done", 5);
      tick();
      check("start_abort_wvalid", {31'd0, wvalid}, 32'd1);

      // Default N=100 in mode 0: done_o 101 cycles after start
      w0 = b_wr_cnt;
      b_start = 1;
      tick();
      b_start = 0;
      n = 1;
      while (!b_done && n < 300) begin
         tick();
         n++;
      end
      check("big_done_cycle", n, 101);
      check("big_count", {25'd0, b_count}, 100);
      check("big_writes", b_wr_cnt - w0, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
